// File: rtl/div_error_monitor.sv
// Recomputes the exact 16/8 quotient/remainder of each sample fed to the approximate array divider
// and accumulates error statistics against it. Ten cycles per in-range sample, two for a rejected one; in_ready is low while busy.
module div_error_monitor #(
    parameter int CNT_W = 32,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      x,
    input  logic [7:0]       y,
    input  logic [7:0]       q_app,
    input  logic [7:0]       r_app,
    input  logic             clr_stats,
    output logic             done,
    output logic [7:0]       q_exact,
    output logic [7:0]       r_exact,
    output logic [7:0]       last_ed,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [7:0]       ed_max
);

    typedef enum logic [1:0] {IDLE, CALC, UPD} state_t;

    state_t      state;
    logic [15:0] x_reg;
    logic [7:0]  y_reg;
    logic [7:0]  qa_reg;
    logic [7:0]  ra_reg;
    logic [7:0]  rem;
    logic [7:0]  quo;
    logic [2:0]  idx;
    logic        oor;

    logic             accept;
    logic             in_range;
    logic [8:0]       t;
    logic [8:0]       t_sub;
    logic [7:0]       ed;
    logic             mismatch;
    logic [ACC_W+7:0] sum_ext;
    logic [ACC_W-1:0] sum_next;

    assign accept   = in_valid && in_ready;
    // The quotient only fits in 8 bits when the top dividend byte is below the divisor.
    assign in_range = (y != 8'd0) && (x[15:8] < y);

    assign t        = {rem, x_reg[idx]};
    assign t_sub    = t - {1'b0, y_reg};

    assign ed       = (qa_reg >= quo) ? (qa_reg - quo) : (quo - qa_reg);
    assign mismatch = (qa_reg != quo) || (ra_reg != rem);

    // Widened add so a narrow accumulator still saturates on a large distance.
    assign sum_ext  = {8'd0, ed_sum} + {{ACC_W{1'b0}}, ed};
    assign sum_next = (sum_ext[ACC_W+7:ACC_W] != 8'd0) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            done       <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            qa_reg     <= '0;
            ra_reg     <= '0;
            rem        <= '0;
            quo        <= '0;
            idx        <= '0;
            oor        <= 1'b0;
            q_exact    <= '0;
            r_exact    <= '0;
            last_ed    <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            skip_cnt   <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_reg    <= x;
                        y_reg    <= y;
                        qa_reg   <= q_app;
                        ra_reg   <= r_app;
                        rem      <= x[15:8];
                        quo      <= '0;
                        idx      <= 3'd7;
                        oor      <= !in_range;
                        in_ready <= 1'b0;
                        state    <= in_range ? CALC : UPD;
                    end
                end
                CALC: begin
                    if (t >= {1'b0, y_reg}) begin
                        quo[idx] <= 1'b1;
                        rem      <= t_sub[7:0];
                    end else begin
                        rem      <= t[7:0];
                    end
                    if (idx == 3'd0) begin
                        state <= UPD;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                UPD: begin
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                    if (oor) begin
                        skip_cnt <= inc_sat(skip_cnt);
                    end else begin
                        q_exact    <= quo;
                        r_exact    <= rem;
                        last_ed    <= ed;
                        sample_cnt <= inc_sat(sample_cnt);
                        if (mismatch) begin
                            err_cnt <= inc_sat(err_cnt);
                        end
                        ed_sum <= sum_next;
                        if (ed > ed_max) begin
                            ed_max <= ed;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
            // Placed last so a clear on the update edge discards that sample's update.
            if (clr_stats) begin
                q_exact    <= '0;
                r_exact    <= '0;
                last_ed    <= '0;
                sample_cnt <= '0;
                err_cnt    <= '0;
                skip_cnt   <= '0;
                ed_sum     <= '0;
                ed_max     <= '0;
            end
        end
    end

endmodule
